// File: rtl/draw_char_grid_if.sv
// VGA timing and colour bundle passed between the overlay pipeline stages.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_char_grid.sv
// Character-grid overlay stage: draws a COLS x ROWS glyph grid from an external font ROM,
// with pixel scaling, per-cell colour, optional opaque background and attribute blink.
module draw_char_grid #(
  parameter int CHAR_W       = 8,
  parameter int CHAR_H       = 16,
  parameter int COLS         = 32,
  parameter int ROWS         = 32,
  parameter int SCALE_LOG2   = 0,
  parameter int FONT_LAT     = 1,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [10:0]                 board_xpos,
  input  logic [10:0]                 board_ypos,
  input  logic                        enable,
  input  logic                        opaque,
  input  logic [11:0]                 bg_rgb,
  output logic [$clog2(COLS)-1:0]     char_col,
  output logic [$clog2(ROWS)-1:0]     char_row,
  output logic [$clog2(CHAR_H)-1:0]   char_line,
  input  logic [CHAR_W-1:0]           char_pixels,
  input  logic [11:0]                 char_fg,
  input  logic                        char_blink,
  vga_if.in                           in,
  vga_if.out                          out
);

  localparam int CW_LOG2 = $clog2(CHAR_W);
  localparam int CH_LOG2 = $clog2(CHAR_H);
  localparam int COL_W   = $clog2(COLS);
  localparam int ROW_W   = $clog2(ROWS);
  localparam logic [11:0] GRID_W = 12'((COLS * CHAR_W) << SCALE_LOG2);
  localparam logic [11:0] GRID_H = 12'((ROWS * CHAR_H) << SCALE_LOG2);
  localparam int FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);
  localparam int BUS_W   = 38;
  localparam int PIPE_W  = BUS_W + 1 + CW_LOG2;

  logic              vsync_q_r;
  logic              vsync_rise_s;
  logic              en_r;
  logic              opq_r;
  logic [10:0]       xpos_r;
  logic [10:0]       ypos_r;
  logic [11:0]       bg_r;
  logic [FC_W-1:0]   frame_cnt_r;
  logic              blink_phase_r;

  logic [10:0]       rx_s;
  logic [10:0]       ry_s;
  logic              inside_s;
  logic [CW_LOG2-1:0] bit_s;

  logic [PIPE_W-1:0] pipe_in_s;
  logic [PIPE_W-1:0] dl_r [FONT_LAT];
  logic [PIPE_W-1:0] d_s;
  logic              d_inside_s;
  logic [CW_LOG2-1:0] d_bit_s;
  logic [BUS_W-1:0]  d_bus_s;
  logic              glyph_on_s;
  logic              blank_s;
  logic [11:0]       rgb_nxt_s;
  logic [BUS_W-1:0]  out_bus_r;

  assign vsync_rise_s = in.vsync & ~vsync_q_r;

  // Frame-edge detection and once-per-frame capture of position and mode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_q_r <= 1'b0;
      en_r      <= 1'b0;
      opq_r     <= 1'b0;
      xpos_r    <= 11'd0;
      ypos_r    <= 11'd0;
      bg_r      <= 12'h000;
    end else begin
      vsync_q_r <= in.vsync;
      if (vsync_rise_s) begin
        en_r   <= enable;
        opq_r  <= opaque;
        xpos_r <= board_xpos;
        ypos_r <= board_ypos;
        bg_r   <= bg_rgb;
      end
    end
  end

  // Blink half-period frame counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
    end else if (vsync_rise_s) begin
      if (frame_cnt_r == FC_LAST) begin
        frame_cnt_r   <= '0;
        blink_phase_r <= ~blink_phase_r;
      end else begin
        frame_cnt_r <= frame_cnt_r + FC_W'(1);
      end
    end
  end

  // Grid-relative position; the scale shift and power-of-2 divides fold into bit slices
  always_comb begin
    rx_s     = in.hcount - xpos_r;
    ry_s     = in.vcount - ypos_r;
    inside_s = en_r & (in.hcount >= xpos_r) & ({1'b0, rx_s} < GRID_W)
                    & (in.vcount >= ypos_r) & ({1'b0, ry_s} < GRID_H);
    bit_s    = rx_s[SCALE_LOG2 +: CW_LOG2];
    if (inside_s) begin
      char_col  = rx_s[SCALE_LOG2 + CW_LOG2 +: COL_W];
      char_row  = ry_s[SCALE_LOG2 + CH_LOG2 +: ROW_W];
      char_line = ry_s[SCALE_LOG2 +: CH_LOG2];
    end else begin
      char_col  = '0;
      char_row  = '0;
      char_line = '0;
    end
  end

  assign pipe_in_s = {inside_s, bit_s, in.vcount, in.vsync, in.vblnk,
                      in.hcount, in.hsync, in.hblnk, in.rgb};

  // Delay line matching the font ROM latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FONT_LAT; i++) begin
        dl_r[i] <= '0;
      end
    end else begin
      dl_r[0] <= pipe_in_s;
      for (int i = 1; i < FONT_LAT; i++) begin
        dl_r[i] <= dl_r[i-1];
      end
    end
  end

  assign d_s        = dl_r[FONT_LAT-1];
  assign d_inside_s = d_s[PIPE_W-1];
  assign d_bit_s    = d_s[BUS_W +: CW_LOG2];
  assign d_bus_s    = d_s[BUS_W-1:0];

  // Pixel select; ~bit is CHAR_W-1-bit because CHAR_W is a power of 2
  always_comb begin
    glyph_on_s = char_pixels[~d_bit_s];
    blank_s    = char_blink & blink_phase_r;
    if (d_inside_s & glyph_on_s & ~blank_s) begin
      rgb_nxt_s = char_fg;
    end else if (d_inside_s & opq_r) begin
      rgb_nxt_s = bg_r;
    end else begin
      rgb_nxt_s = d_bus_s[11:0];
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_bus_r <= '0;
    end else begin
      out_bus_r <= {d_bus_s[BUS_W-1:12], rgb_nxt_s};
    end
  end

  assign {out.vcount, out.vsync, out.vblnk, out.hcount, out.hsync, out.hblnk, out.rgb} = out_bus_r;

endmodule

// File: tb/tb_draw_char_grid.sv
// Scoreboard bench for draw_char_grid: a default-geometry instance and a scaled, longer-latency one.
module tb_draw_char_grid;
  localparam int LAT_A = 2;
  localparam int LAT_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [10:0] board_xpos, board_ypos;
  logic        enable, opaque;
  logic [11:0] bg_rgb;
  logic [4:0]  col_a, row_a, col_b, row_b;
  logic [3:0]  line_a, line_b;
  logic [7:0]  pix_a, pix_b;
  logic [11:0] fg_a, fg_b;
  logic        blink_a, blink_b;

  vga_if in_if ();
  vga_if out_a ();
  vga_if out_b ();

  draw_char_grid #(.BLINK_FRAMES(2)) dut_a (
    .clk(clk), .rst(rst), .board_xpos(board_xpos), .board_ypos(board_ypos),
    .enable(enable), .opaque(opaque), .bg_rgb(bg_rgb),
    .char_col(col_a), .char_row(row_a), .char_line(line_a),
    .char_pixels(pix_a), .char_fg(fg_a), .char_blink(blink_a),
    .in(in_if), .out(out_a));

  draw_char_grid #(.SCALE_LOG2(1), .FONT_LAT(3), .BLINK_FRAMES(2)) dut_b (
    .clk(clk), .rst(rst), .board_xpos(board_xpos), .board_ypos(board_ypos),
    .enable(enable), .opaque(opaque), .bg_rgb(bg_rgb),
    .char_col(col_b), .char_row(row_b), .char_line(line_b),
    .char_pixels(pix_b), .char_fg(fg_b), .char_blink(blink_b),
    .in(in_if), .out(out_b));

  // ROM contents: {blink, fg, pixels}, fg and pixels vary per cell/line
  logic [7:0]  rom_pix;
  logic [11:0] rom_fg;
  logic        rom_blink;

  function automatic logic [20:0] rom_word(input logic [4:0] c, input logic [4:0] r, input logic [3:0] l);
    rom_word = {rom_blink, rom_fg ^ {r, c, 2'b00}, rom_pix ^ {l, 4'b0000}};
  endfunction

  logic [20:0] rom_a_q;
  logic [20:0] rom_b_q [3];
  always @(posedge clk) begin
    rom_a_q    <= rom_word(col_a, row_a, line_a);
    rom_b_q[0] <= rom_word(col_b, row_b, line_b);
    rom_b_q[1] <= rom_b_q[0];
    rom_b_q[2] <= rom_b_q[1];
  end
  assign {blink_a, fg_a, pix_a} = rom_a_q;
  assign {blink_b, fg_b, pix_b} = rom_b_q[2];

  // Reference model state
  logic        m_en, m_opq, m_prev_vs;
  logic [10:0] m_xp, m_yp;
  logic [11:0] m_bg;
  int          m_rises;
  logic [37:0] qa[$];
  logic [37:0] qb[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic void geo(input int hc, input int vc, input int sc, output bit ins,
                              output int col, output int row, output int line, output int bt);
    int xp, yp, rx, ry;
    xp = int'(m_xp);
    yp = int'(m_yp);
    rx = hc - xp;
    ry = vc - yp;
    ins = m_en && (hc >= xp) && (rx < (256 << sc)) && (vc >= yp) && (ry < (512 << sc));
    if (ins) begin
      col = (rx >> sc) / 8;  row = (ry >> sc) / 16;
      line = (ry >> sc) % 16; bt = (rx >> sc) % 8;
    end else begin
      col = 0; row = 0; line = 0; bt = 0;
    end
  endfunction

  function automatic logic [37:0] expect_out(input int hc, input int vc, input logic [11:0] rgb,
                                             input logic vs, input int sc);
    bit ins;
    int col, row, line, bt;
    logic [20:0] w;
    logic [11:0] o;
    logic [10:0] h, v;
    geo(hc, vc, sc, ins, col, row, line, bt);
    w = rom_word(5'(col), 5'(row), 4'(line));
    o = rgb;
    if (ins && w[7 - bt] && !(w[20] && ((m_rises / 2) % 2 == 1))) o = w[19:8];
    else if (ins && m_opq) o = m_bg;
    h = 11'(hc);
    v = 11'(vc);
    expect_out = {v, vs, v[2], h, h[3], h[5], o};
  endfunction

  task automatic drive(input int hc, input int vc, input logic [11:0] rgb, input logic vs);
    bit ins;
    int col, row, line, bt;
    logic [37:0] e, got;
    in_if.hcount = 11'(hc);
    in_if.vcount = 11'(vc);
    in_if.vsync  = vs;
    in_if.vblnk  = in_if.vcount[2];
    in_if.hsync  = in_if.hcount[3];
    in_if.hblnk  = in_if.hcount[5];
    in_if.rgb    = rgb;
    #1;
    geo(hc, vc, 0, ins, col, row, line, bt);
    n_checks++;
    if ({col_a, row_a, line_a} !== {5'(col), 5'(row), 4'(line)}) begin
      n_fail++;
      $display("FAIL addr_a h=%0d v=%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
               hc, vc, col_a, row_a, line_a, col, row, line);
    end
    geo(hc, vc, 1, ins, col, row, line, bt);
    n_checks++;
    if ({col_b, row_b, line_b} !== {5'(col), 5'(row), 4'(line)}) begin
      n_fail++;
      $display("FAIL addr_b h=%0d v=%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
               hc, vc, col_b, row_b, line_b, col, row, line);
    end
    qa.push_back(expect_out(hc, vc, rgb, vs, 0));
    qb.push_back(expect_out(hc, vc, rgb, vs, 1));
    if (vs && !m_prev_vs) begin
      m_en = enable; m_opq = opaque; m_xp = board_xpos; m_yp = board_ypos; m_bg = bg_rgb;
      m_rises++;
    end
    m_prev_vs = vs;
    @(posedge clk);
    #1;
    if (qa.size() >= LAT_A) begin
      e = qa.pop_front();
      got = {out_a.vcount, out_a.vsync, out_a.vblnk, out_a.hcount, out_a.hsync, out_a.hblnk, out_a.rgb};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL out_a: got %h want %h (rgb got %h want %h)", got, e, got[11:0], e[11:0]);
      end
    end
    if (qb.size() >= LAT_B) begin
      e = qb.pop_front();
      got = {out_b.vcount, out_b.vsync, out_b.vblnk, out_b.hcount, out_b.hsync, out_b.hblnk, out_b.rgb};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL out_b: got %h want %h (rgb got %h want %h)", got, e, got[11:0], e[11:0]);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(2040, 2040, 12'(12'h0A5 + i), 1'b0);
  endtask

  task automatic vsync_pulse();
    idle(5);
    drive(2040, 2040, 12'h000, 1'b1);
    drive(2040, 2040, 12'h000, 1'b1);
    idle(5);
  endtask

  task automatic apply_reset();
    logic [37:0] got_a, got_b;
    rst = 1'b0;
    #1;
    got_a = {out_a.vcount, out_a.vsync, out_a.vblnk, out_a.hcount, out_a.hsync, out_a.hblnk, out_a.rgb};
    got_b = {out_b.vcount, out_b.vsync, out_b.vblnk, out_b.hcount, out_b.hsync, out_b.hblnk, out_b.rgb};
    n_checks++;
    if (got_a !== 38'd0 || got_b !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_out: got %h / %h want 0", got_a, got_b);
    end
    n_checks++;
    if ({col_a, row_a, line_a, col_b, row_b, line_b} !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_addr: got %h want 0", {col_a, row_a, line_a, col_b, row_b, line_b});
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    qa.delete();
    qb.delete();
    repeat (LAT_A - 1) qa.push_back(38'd0);
    repeat (LAT_B - 1) qb.push_back(38'd0);
    m_en = 1'b0; m_opq = 1'b0; m_xp = 11'd0; m_yp = 11'd0; m_bg = 12'h000;
    m_prev_vs = 1'b0; m_rises = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    idle(4);
  endtask

  task automatic test_passthrough();
    enable = 1'b0; board_xpos = 11'd100; board_ypos = 11'd50;
    vsync_pulse();
    for (int h = 95; h < 111; h++) drive(h, 50, 12'h123, 1'b0);
  endtask

  task automatic test_geometry();
    enable = 1'b1; opaque = 1'b0; board_xpos = 11'd100; board_ypos = 11'd50;
    rom_pix = 8'hF0; rom_fg = 12'h20A; rom_blink = 1'b0;
    vsync_pulse();
    for (int h = 96; h < 124; h++) drive(h, 50, 12'h123, 1'b0);
    for (int h = 353; h < 359; h++) drive(h, 50, 12'h456, 1'b0);
    for (int h = 608; h < 614; h++) drive(h, 60, 12'h456, 1'b0);
    for (int v = 85; v < 90; v++) drive(116, v, 12'h789, 1'b0);
    for (int v = 560; v < 564; v++) drive(100, v, 12'h321, 1'b0);
    for (int v = 1072; v < 1076; v++) drive(100, v, 12'h321, 1'b0);
    for (int v = 40; v < 200; v += 13)
      for (int h = 100; h < 700; h += 37) drive(h, v, 12'h654, 1'b0);
  endtask

  task automatic test_opaque();
    opaque = 1'b1; bg_rgb = 12'hFFF;
    vsync_pulse();
    for (int h = 96; h < 114; h++) drive(h, 60, 12'h123, 1'b0);
    for (int h = 350; h < 362; h++) drive(h, 60, 12'h123, 1'b0);
    drive(100, 49, 12'h0F0, 1'b0);
    opaque = 1'b0;
  endtask

  task automatic test_blink();
    apply_reset();
    enable = 1'b1; opaque = 1'b0; board_xpos = 11'd100; board_ypos = 11'd50;
    rom_blink = 1'b1;
    for (int f = 0; f < 6; f++) begin
      vsync_pulse();
      for (int h = 99; h < 106; h++) drive(h, 50, 12'h123, 1'b0);
    end
    opaque = 1'b1; bg_rgb = 12'h0C3;
    vsync_pulse();
    for (int h = 99; h < 106; h++) drive(h, 50, 12'h123, 1'b0);
    rom_blink = 1'b0; opaque = 1'b0;
  endtask

  task automatic test_midframe();
    board_xpos = 11'd100;
    vsync_pulse();
    for (int h = 100; h < 104; h++) drive(h, 50, 12'h111, 1'b0);
    board_xpos = 11'd200;
    for (int h = 100; h < 104; h++) drive(h, 51, 12'h222, 1'b0);
    for (int h = 200; h < 204; h++) drive(h, 51, 12'h222, 1'b0);
    vsync_pulse();
    for (int h = 100; h < 104; h++) drive(h, 52, 12'h333, 1'b0);
    for (int h = 200; h < 204; h++) drive(h, 52, 12'h333, 1'b0);
  endtask

  task automatic test_wrap();
    board_xpos = 11'd1900;
    vsync_pulse();
    for (int h = 2040; h < 2048; h++) drive(h, 50, 12'h444, 1'b0);
    for (int h = 0; h < 6; h++) drive(h, 50, 12'h555, 1'b0);
    board_xpos = 11'd100;
  endtask

  task automatic test_reset_midline();
    vsync_pulse();
    for (int h = 100; h < 106; h++) drive(h, 50, 12'h777, 1'b0);
    apply_reset();
    for (int h = 100; h < 108; h++) drive(h, 50, 12'h888, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    board_xpos = 11'd0; board_ypos = 11'd0; enable = 1'b0; opaque = 1'b0; bg_rgb = 12'h000;
    rom_pix = 8'hF0; rom_fg = 12'h20A; rom_blink = 1'b0;
    in_if.hcount = 11'd0; in_if.vcount = 11'd0; in_if.vsync = 1'b0; in_if.vblnk = 1'b0;
    in_if.hsync = 1'b0; in_if.hblnk = 1'b0; in_if.rgb = 12'h000;
    @(posedge clk);
    #1;
    test_reset();
    test_passthrough();
    test_geometry();
    test_opaque();
    test_blink();
    test_midframe();
    test_wrap();
    test_reset_midline();
    idle(6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/draw_char_grid.md
Name: draw_char_grid

Overview:
- Parametrised character-grid overlay stage for the VGA pipeline; generalises the existing board character drawer.
- Draws a COLS x ROWS grid of CHAR_W x CHAR_H glyphs at a board position, with integer pixel scaling, per-cell foreground colour, optional opaque background, and attribute-driven blink.
- Sits between the board-drawing and mouse-drawing stages; talks to an external char-code/font ROM with fixed latency.
- Position and mode are sampled once per frame so that mid-frame changes cannot tear the image.

Parameters:
- CHAR_W, 8: glyph width in pixels; must be a power of 2.
- CHAR_H, 16: glyph height in lines; must be a power of 2.
- COLS, 32: number of grid columns.
- ROWS, 32: number of grid rows.
- SCALE_LOG2, 0: pixel scale = 2**SCALE_LOG2; legal range 0..2.
- FONT_LAT, 1: cycles from address out to char_pixels/char_fg/char_blink valid; must be >= 1.
- BLINK_FRAMES, 30: frames per blink half-period; must be >= 1.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-low reset.
- board_xpos  in  11  grid left edge; sampled per frame.
- board_ypos  in  11  grid top edge; sampled per frame.
- enable  in  1  overlay enable; sampled per frame.
- opaque  in  1  1 = paint bg_rgb under glyph-off pixels inside the grid; sampled per frame.
- bg_rgb  in  12  background colour; sampled per frame.
- char_col  out  $clog2(COLS)  cell column address to ROM.
- char_row  out  $clog2(ROWS)  cell row address to ROM.
- char_line  out  $clog2(CHAR_H)  glyph line to ROM.
- char_pixels  in  CHAR_W  glyph row; MSB is the leftmost pixel.
- char_fg  in  12  foreground colour for the addressed cell.
- char_blink  in  1  blink attribute for the addressed cell.
- in  vga_if.in  -  upstream timing and rgb.
- out  vga_if.out  -  downstream timing and rgb.

Behaviour:
- Reset (rst=0, asynchronous):
  - All out fields are 0.
  - Shadow registers: enable=0, opaque=0, xpos=0, ypos=0, bg=0.
  - Frame counter=0, blink_phase=0, all delay-line contents 0.
  - With the shadow enable=0, the block is a pure delay line.
- Frame sampling:
  - vsync_rise = in.vsync & ~vsync_q, where vsync_q is a registered copy of in.vsync.
  - On vsync_rise, enable, opaque, board_xpos, board_ypos and bg_rgb load into the shadow registers.
  - All geometry and mode decisions use the shadow values only.
- Geometry (combinational from in.hcount/in.vcount and the shadow registers):
  - rx = hcount - xpos and ry = vcount - ypos, both 11-bit.
  - inside = enable & (hcount >= xpos) & (rx < COLS*CHAR_W<<SCALE_LOG2) & (vcount >= ypos) & (ry < ROWS*CHAR_H<<SCALE_LOG2).
  - sx = rx >> SCALE_LOG2 and sy = ry >> SCALE_LOG2.
  - char_col = sx / CHAR_W; char_row = sy / CHAR_H; char_line = sy mod CHAR_H.
  - When inside=0, all three address outputs are 0.
- Pipeline:
  - The full in bundle, inside and bit index (sx mod CHAR_W) are delayed through a FONT_LAT-stage delay line, aligned with the ROM data.
  - One output register stage follows the delay line.
  - Total latency from in to out is FONT_LAT+1 cycles for every field.
  - Timing fields pass through unchanged.
- Pixel select, at the delayed stage:
  - glyph_on = char_pixels[CHAR_W-1-bit].
  - blank = char_blink & blink_phase.
  - If inside & glyph_on & ~blank: rgb = char_fg.
  - Else if inside & opaque: rgb = bg_rgb.
  - Else: rgb = delayed in.rgb.
  - Blanking is not masked here; an upstream stage guarantees rgb is 0 during blanking.
- Blink:
  - On each vsync_rise the frame counter increments.
  - At BLINK_FRAMES-1 the counter wraps to 0 and blink_phase toggles on the same edge.
  - BLINK_FRAMES=1 toggles blink_phase every frame.
- Boundaries:
  - With xpos+grid width > 2047, rx wraps; comparisons stay 11-bit unsigned and no pixels are drawn past the wrap.
  - The last column/row pixel (rx = width-1) is inside; rx = width is outside.
  - vsync_rise coinciding with a mode change: the new value takes effect for the next frame's pixels.
  - Reset asserted mid-line: out goes to 0 immediately and the pipeline refills after release, with FONT_LAT+1 cycles of zeroed output.

Test Plan:
- Reset, then drive 1024x768 timing with enable=0 and in.rgb=12'h123 -> out equals in delayed by 2 cycles; char_col/row/line stay 0.
- Defaults with enable=1, xpos=100, ypos=50, and the ROM model returning 8'hF0 with char_fg=12'h20A → at vcount=50, hcount=100..103 out.rgb=12'h20A; hcount=104..107 out.rgb=in.rgb; hcount=99 and hcount=356 are untouched.
- SCALE_LOG2=1 → hcount=116 yields char_col=1, and ry=37 yields char_line=2; each glyph pixel covers a 2x2 block.
- opaque=1, bg_rgb=12'hFFF → glyph-off pixels inside the grid read 12'hFFF; pixels outside the grid pass in.rgb.
- char_blink=1, BLINK_FRAMES=2 → glyph visible in frames 0-1, replaced by in.rgb or bg in frames 2-3, visible again in frame 4.
- Change board_xpos from 100 to 200 mid-frame → the current frame keeps 100 and the next frame after vsync_rise uses 200.
- Repeat the geometry test with FONT_LAT=3 → latency is 4 cycles with the same pixel mapping.
